// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - shared state, opcode and ALU encodings for the instruction sequencer
package instr_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_OR    = 3'b100;
    localparam logic [2:0] OP_LOAD  = 3'b101;
    localparam logic [2:0] OP_STORE = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    function automatic logic [1:0] alu_op_of(input logic [2:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/instr_sequencer_wait_timer.sv
// rtl/instr_sequencer_wait_timer.sv - memory wait counter with timeout compare
module mem_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic ready,
    output logic timeout
);

    logic [7:0] count;

    // Counter idles at zero whenever no request is outstanding, so each request starts fresh.
    always_ff @(posedge clk) begin
        if (reset || !active || ready) begin
            count <= 8'd0;
        end else begin
            count <= count + 8'd1;
        end
    end

    assign timeout = active && !ready && (count == 8'(WAIT_MAX - 1));

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle fetch/decode/execute control FSM
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int PC_W     = 15,
    parameter int WAIT_MAX = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      opcode,
    input  logic            mem_ready,
    input  logic [31:0]     mem_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic            mem_sel,
    output logic [PC_W-1:0] pc,
    output logic [31:0]     ir,
    output logic            ir_load,
    output logic            rf_we,
    output logic            rf_src,
    output logic [1:0]      alu_op,
    output logic            busy,
    output logic            halted,
    output logic            fault
);

    state_t state;
    logic   resp;
    logic   store_op;
    logic   timeout;

    mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .active  (mem_req),
        .ready   (mem_ready),
        .timeout (timeout)
    );

    // Request states spend one response cycle after completion (mem_req low) before moving on.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            pc       <= '0;
            ir       <= '0;
            resp     <= 1'b0;
            store_op <= 1'b0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_sel  <= 1'b0;
            ir_load  <= 1'b0;
            rf_we    <= 1'b0;
            rf_src   <= 1'b0;
            alu_op   <= ALU_ADD;
            busy     <= 1'b0;
            halted   <= 1'b0;
            fault    <= 1'b0;
        end else begin
            ir_load <= 1'b0;
            rf_we   <= 1'b0;
            rf_src  <= 1'b0;
            alu_op  <= ALU_ADD;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_FETCH;
                        pc      <= '0;
                        mem_req <= 1'b1;
                        mem_sel <= 1'b0;
                        mem_we  <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (resp) begin
                        resp  <= 1'b0;
                        state <= S_DECODE;
                    end else if (mem_ready) begin
                        ir      <= mem_rdata;
                        ir_load <= 1'b1;
                        mem_req <= 1'b0;
                        resp    <= 1'b1;
                    end else if (timeout) begin
                        state   <= S_FAULT;
                        mem_req <= 1'b0;
                        busy    <= 1'b0;
                        fault   <= 1'b1;
                    end
                end
                S_DECODE: begin
                    case (opcode)
                        OP_NOP: begin
                            state   <= S_FETCH;
                            pc      <= pc + 1'b1;
                            mem_req <= 1'b1;
                            mem_sel <= 1'b0;
                            mem_we  <= 1'b0;
                        end
                        OP_LOAD, OP_STORE: begin
                            state    <= S_MEM;
                            store_op <= (opcode == OP_STORE);
                            mem_req  <= 1'b1;
                            mem_sel  <= 1'b1;
                            mem_we   <= (opcode == OP_STORE);
                        end
                        OP_HALT: begin
                            state  <= S_HALT;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end
                        default: begin
                            state  <= S_EXEC;
                            alu_op <= alu_op_of(opcode);
                            rf_we  <= 1'b1;
                            rf_src <= 1'b0;
                        end
                    endcase
                end
                S_EXEC, S_WB: begin
                    state   <= S_FETCH;
                    pc      <= pc + 1'b1;
                    mem_req <= 1'b1;
                    mem_sel <= 1'b0;
                    mem_we  <= 1'b0;
                end
                S_MEM: begin
                    if (resp) begin
                        resp <= 1'b0;
                        if (store_op) begin
                            state   <= S_FETCH;
                            pc      <= pc + 1'b1;
                            mem_req <= 1'b1;
                        end else begin
                            state  <= S_WB;
                            rf_we  <= 1'b1;
                            rf_src <= 1'b1;
                        end
                    end else if (mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_sel <= 1'b0;
                        resp    <= 1'b1;
                    end else if (timeout) begin
                        state   <= S_FAULT;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_sel <= 1'b0;
                        busy    <= 1'b0;
                        fault   <= 1'b1;
                    end
                end
                S_HALT, S_FAULT: begin
                    state <= state;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed vector bench for instr_sequencer
module tb_instr_sequencer;

    localparam int PC_W     = 4;
    localparam int WAIT_MAX = 4;

    localparam logic [10:0] C_REQ  = 11'h400;
    localparam logic [10:0] C_SEL  = 11'h200;
    localparam logic [10:0] C_WE   = 11'h100;
    localparam logic [10:0] C_ILD  = 11'h080;
    localparam logic [10:0] C_RFWE = 11'h040;
    localparam logic [10:0] C_RSRC = 11'h020;
    localparam logic [10:0] C_BUSY = 11'h004;
    localparam logic [10:0] C_HALT = 11'h002;
    localparam logic [10:0] C_FLT  = 11'h001;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [2:0]      opcode;
    logic            mem_ready;
    logic [31:0]     mem_rdata;
    logic            mem_req;
    logic            mem_we;
    logic            mem_sel;
    logic [PC_W-1:0] pc;
    logic [31:0]     ir;
    logic            ir_load;
    logic            rf_we;
    logic            rf_src;
    logic [1:0]      alu_op;
    logic            busy;
    logic            halted;
    logic            fault;
    logic [10:0]     obs;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic rf_seen;

    typedef struct {
        logic        start;
        logic        ready;
        logic [31:0] rdata;
        logic [10:0] exp_ctl;
        logic [3:0]  exp_pc;
    } vec_t;

    vec_t vecs[13];

    instr_sequencer #(.PC_W(PC_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_sel   (mem_sel),
        .pc        (pc),
        .ir        (ir),
        .ir_load   (ir_load),
        .rf_we     (rf_we),
        .rf_src    (rf_src),
        .alu_op    (alu_op),
        .busy      (busy),
        .halted    (halted),
        .fault     (fault)
    );

    // Stand-in decoder: opcode lives in the low bits of the instruction word.
    assign opcode = ir[2:0];
    assign obs = {mem_req, mem_sel, mem_we, ir_load, rf_we, rf_src, alu_op, busy, halted, fault};

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic step();
        @(negedge clk);
        rf_seen = rf_seen | rf_we;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
        step(); step();
        reset = 1'b0;
        rf_seen = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 32'h0,         11'h000,               4'd0};
        vecs[1]  = '{1'b0, 1'b1, 32'hA5A5_0001, C_REQ | C_BUSY,        4'd0};
        vecs[2]  = '{1'b0, 1'b1, 32'hDEAD_BEEF, C_ILD | C_BUSY,        4'd0};
        vecs[3]  = '{1'b0, 1'b1, 32'h0,         C_BUSY,                4'd0};
        vecs[4]  = '{1'b0, 1'b1, 32'h0,         C_RFWE | C_BUSY,       4'd0};
        vecs[5]  = '{1'b0, 1'b1, 32'h1234_5670, C_REQ | C_BUSY,        4'd1};
        vecs[6]  = '{1'b0, 1'b1, 32'h0,         C_ILD | C_BUSY,        4'd1};
        vecs[7]  = '{1'b0, 1'b1, 32'h0,         C_BUSY,                4'd1};
        vecs[8]  = '{1'b0, 1'b1, 32'h0000_0007, C_REQ | C_BUSY,        4'd2};
        vecs[9]  = '{1'b0, 1'b1, 32'h0,         C_ILD | C_BUSY,        4'd2};
        vecs[10] = '{1'b0, 1'b1, 32'h0,         C_BUSY,                4'd2};
        vecs[11] = '{1'b1, 1'b1, 32'h0,         C_HALT,                4'd2};
        vecs[12] = '{1'b0, 1'b1, 32'h0,         C_HALT,                4'd2};

        // Program {ADD, NOP, HALT}, zero-wait memory
        do_reset();
        chk("reset_ir", ir, 32'h0);
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("t1_ctl_c%0d", i), 32'(obs), 32'(vecs[i].exp_ctl));
            chk($sformatf("t1_pc_c%0d", i), 32'(pc), 32'(vecs[i].exp_pc));
            start = vecs[i].start; mem_ready = vecs[i].ready; mem_rdata = vecs[i].rdata;
            step();
        end
        chk("t1_ir_halt", ir, 32'h0000_0007);

        // LOAD with memory answering on the 4th request cycle
        do_reset();
        start = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h0000_0005;
        step(); start = 1'b0;
        step(); mem_ready = 1'b0;
        step();
        step();
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("t2_mem_c%0d", j), 32'(obs), 32'(C_REQ | C_SEL | C_BUSY));
            mem_ready = (j == 3);
            step();
        end
        mem_ready = 1'b0;
        chk("t2_resp", 32'(obs), 32'(C_BUSY));
        step();
        chk("t2_wb", 32'(obs), 32'(C_RFWE | C_RSRC | C_BUSY));
        step();
        chk("t2_next_fetch", 32'(obs), 32'(C_REQ | C_BUSY));
        chk("t2_pc", 32'(pc), 32'd1);

        // STORE, zero-wait
        do_reset();
        start = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h0000_0006;
        step(); start = 1'b0;
        step(); step(); step();
        chk("t3_mem", 32'(obs), 32'(C_REQ | C_SEL | C_WE | C_BUSY));
        step();
        chk("t3_resp", 32'(obs), 32'(C_BUSY));
        step();
        chk("t3_fetch", 32'(obs), 32'(C_REQ | C_BUSY));
        chk("t3_pc", 32'(pc), 32'd1);
        chk("t3_no_rf_we", 32'(rf_seen), 32'd0);

        // Fetch timeout with mem_ready never asserted
        do_reset();
        start = 1'b1;
        step(); start = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            chk($sformatf("t4_wait_c%0d", j), 32'(obs), 32'(C_REQ | C_BUSY));
            step();
        end
        chk("t4_fault", 32'(obs), 32'(C_FLT));
        start = 1'b1;
        step(); start = 1'b0;
        chk("t4_fault_sticky", 32'(obs), 32'(C_FLT));
        reset = 1'b1;
        step(); reset = 1'b0;
        chk("t4_after_reset", 32'(obs), 32'h0);

        // mem_ready on exactly the WAIT_MAX-th cycle
        do_reset();
        start = 1'b1;
        step(); start = 1'b0;
        step(); step(); step();
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_0001;
        step(); mem_ready = 1'b0;
        chk("t5_ir_load", 32'(obs), 32'(C_ILD | C_BUSY));
        chk("t5_ir", ir, 32'hCAFE_0001);

        // Reset during MEM after a NOP; start pulse while busy
        do_reset();
        start = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h0;
        step(); start = 1'b0;
        step(); step();
        mem_rdata = 32'h0000_0005;
        step();
        step(); mem_ready = 1'b0;
        step();
        step();
        chk("t6_mem", 32'(obs), 32'(C_REQ | C_SEL | C_BUSY));
        start = 1'b1;
        step(); start = 1'b0;
        chk("t6_start_ignored", 32'(obs), 32'(C_REQ | C_SEL | C_BUSY));
        chk("t6_pc_before", 32'(pc), 32'd1);
        reset = 1'b1;
        step(); reset = 1'b0;
        chk("t6_req_dropped", 32'(obs), 32'h0);
        chk("t6_pc_reset", 32'(pc), 32'd0);

        // pc wrap on NOP stream
        do_reset();
        start = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h0;
        step(); start = 1'b0;
        for (int j = 0; j < 45; j++) step();
        chk("t7_pc_max", 32'(pc), 32'd15);
        for (int j = 0; j < 3; j++) step();
        chk("t7_pc_wrap", 32'(pc), 32'd0);
        chk("t7_fetch", 32'(obs), 32'(C_REQ | C_BUSY));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
